// File: rtl/pll_lock_supervisor.sv
// rPLL sequencer: drives RESET and dynamic divider selects, qualifies LOCK with a
// stability window, generates the user reset and retries failed lock attempts.
module pll_lock_supervisor #(
    parameter int         RESET_CYCLES = 16,
    parameter int         LOCK_STABLE  = 1024,
    parameter int         LOCK_TIMEOUT = 65536,
    parameter int         MAX_RETRY    = 3,
    parameter int         INIT_IDIV    = 2,
    parameter int         INIT_FBDIV   = 3,
    parameter logic [5:0] INIT_ODSEL   = 6'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [5:0] cfg_idiv,
    input  logic [5:0] cfg_fbdiv,
    input  logic [5:0] cfg_odsel,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       locked,
    output logic       user_rst,
    output logic       fault,
    output logic [1:0] attempt
);

    localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int ST_W = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
    localparam int TO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(LOCK_STABLE - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRY);

    // The rPLL selects are the bitwise complement of the divider values.
    localparam logic [5:0] INIT_IDSEL  = ~6'(INIT_IDIV);
    localparam logic [5:0] INIT_FBDSEL = ~6'(INIT_FBDIV);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    state_t          state_reg, state_next;
    logic [RC_W-1:0] rst_cnt_reg, rst_cnt_next;
    logic [ST_W-1:0] st_cnt_reg, st_cnt_next;
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic [RT_W-1:0] retry_reg, retry_next;
    logic [5:0]      idsel_reg, idsel_next;
    logic [5:0]      fbdsel_reg, fbdsel_next;
    logic [5:0]      odsel_reg, odsel_next;
    logic            pll_reset_reg, pll_reset_next;
    logic            locked_reg, locked_next;
    logic            user_rst_reg, user_rst_next;
    logic            fault_reg, fault_next;
    logic            cfg_ready_reg, cfg_ready_next;
    logic [1:0]      attempt_reg, attempt_next;
    logic            lock_meta_reg, lock_s_reg;
    logic            cfg_take;

    assign cfg_take = cfg_valid && cfg_ready_reg;

    always_comb begin
        state_next   = state_reg;
        rst_cnt_next = rst_cnt_reg;
        st_cnt_next  = st_cnt_reg;
        to_cnt_next  = to_cnt_reg;
        retry_next   = retry_reg;
        idsel_next   = idsel_reg;
        fbdsel_next  = fbdsel_reg;
        odsel_next   = odsel_reg;

        case (state_reg)
            RESET_PLL: begin
                if (rst_cnt_reg == RC_LAST) begin
                    state_next  = WAIT_LOCK;
                    to_cnt_next = '0;
                end else begin
                    rst_cnt_next = rst_cnt_reg + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (lock_s_reg) begin
                    state_next  = STABLE;
                    st_cnt_next = '0;
                end else if (to_cnt_reg == TO_LAST) begin
                    if (retry_reg < RT_MAX) begin
                        retry_next   = retry_reg + 1'b1;
                        state_next   = RESET_PLL;
                        rst_cnt_next = '0;
                    end else begin
                        state_next = FAULT;
                    end
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end
            STABLE: begin
                // A dropout restarts qualification without using up a retry.
                if (!lock_s_reg) begin
                    state_next  = WAIT_LOCK;
                    to_cnt_next = '0;
                end else if (st_cnt_reg == ST_LAST) begin
                    state_next = RUN;
                    retry_next = '0;
                end else begin
                    st_cnt_next = st_cnt_reg + 1'b1;
                end
            end
            RUN: begin
                if (cfg_take || !lock_s_reg) begin
                    state_next   = RESET_PLL;
                    rst_cnt_next = '0;
                    retry_next   = '0;
                end
                if (cfg_take) begin
                    idsel_next  = ~cfg_idiv;
                    fbdsel_next = ~cfg_fbdiv;
                    odsel_next  = cfg_odsel;
                end
            end
            FAULT: begin
                if (cfg_take) begin
                    state_next   = RESET_PLL;
                    rst_cnt_next = '0;
                    retry_next   = '0;
                    idsel_next   = ~cfg_idiv;
                    fbdsel_next  = ~cfg_fbdiv;
                    odsel_next   = cfg_odsel;
                end
            end
            default: begin
                state_next   = RESET_PLL;
                rst_cnt_next = '0;
            end
        endcase

        // Outputs are registered copies decoded from the state being entered.
        pll_reset_next = (state_next == RESET_PLL) || (state_next == FAULT);
        locked_next    = (state_next == RUN);
        user_rst_next  = (state_next != RUN);
        fault_next     = (state_next == FAULT);
        cfg_ready_next = (state_next == RUN) || (state_next == FAULT);
        attempt_next   = (int'(retry_next) > 3) ? 2'd3 : 2'(retry_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RESET_PLL;
            rst_cnt_reg   <= '0;
            st_cnt_reg    <= '0;
            to_cnt_reg    <= '0;
            retry_reg     <= '0;
            idsel_reg     <= INIT_IDSEL;
            fbdsel_reg    <= INIT_FBDSEL;
            odsel_reg     <= INIT_ODSEL;
            pll_reset_reg <= 1'b1;
            locked_reg    <= 1'b0;
            user_rst_reg  <= 1'b1;
            fault_reg     <= 1'b0;
            cfg_ready_reg <= 1'b0;
            attempt_reg   <= 2'd0;
            lock_meta_reg <= 1'b0;
            lock_s_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rst_cnt_reg   <= rst_cnt_next;
            st_cnt_reg    <= st_cnt_next;
            to_cnt_reg    <= to_cnt_next;
            retry_reg     <= retry_next;
            idsel_reg     <= idsel_next;
            fbdsel_reg    <= fbdsel_next;
            odsel_reg     <= odsel_next;
            pll_reset_reg <= pll_reset_next;
            locked_reg    <= locked_next;
            user_rst_reg  <= user_rst_next;
            fault_reg     <= fault_next;
            cfg_ready_reg <= cfg_ready_next;
            attempt_reg   <= attempt_next;
            lock_meta_reg <= pll_lock;
            lock_s_reg    <= lock_meta_reg;
        end
    end

    assign pll_reset  = pll_reset_reg;
    assign pll_idsel  = idsel_reg;
    assign pll_fbdsel = fbdsel_reg;
    assign pll_odsel  = odsel_reg;
    assign locked     = locked_reg;
    assign user_rst   = user_rst_reg;
    assign fault      = fault_reg;
    assign cfg_ready  = cfg_ready_reg;
    assign attempt    = attempt_reg;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: expected output snapshots are queued
// against a cycle number when stimulus is driven, then compared when that cycle arrives.
module tb_pll_lock_supervisor;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [5:0] cfg_idiv;
    logic [5:0] cfg_fbdiv;
    logic [5:0] cfg_odsel;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] pll_idsel;
    logic [5:0] pll_fbdsel;
    logic [5:0] pll_odsel;
    logic       locked;
    logic       user_rst;
    logic       fault;
    logic [1:0] attempt;

    pll_lock_supervisor #(
        .RESET_CYCLES(4),
        .LOCK_STABLE (8),
        .LOCK_TIMEOUT(32),
        .MAX_RETRY   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_idiv  (cfg_idiv),
        .cfg_fbdiv (cfg_fbdiv),
        .cfg_odsel (cfg_odsel),
        .pll_lock  (pll_lock),
        .pll_reset (pll_reset),
        .pll_idsel (pll_idsel),
        .pll_fbdsel(pll_fbdsel),
        .pll_odsel (pll_odsel),
        .locked    (locked),
        .user_rst  (user_rst),
        .fault     (fault),
        .attempt   (attempt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       pll_reset;
        logic       locked;
        logic       user_rst;
        logic       fault;
        logic       cfg_ready;
        logic [1:0] attempt;
        logic [5:0] idsel;
        logic [5:0] fbdsel;
        logic [5:0] odsel;
    } snap_t;

    typedef struct {
        int    cyc;
        string tag;
        snap_t exp;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
        end else begin
            $display("ok   %s @cyc %0d: %h", tag, cyc, obs);
        end
    endtask

    function automatic snap_t mk(input logic rs, input logic lk, input logic fl, input logic rdy,
                                 input logic [1:0] att, input logic [5:0] idiv,
                                 input logic [5:0] fbdiv, input logic [5:0] od);
        snap_t s;
        s.pll_reset = rs;
        s.locked    = lk;
        s.user_rst  = !lk;
        s.fault     = fl;
        s.cfg_ready = rdy;
        s.attempt   = att;
        s.idsel     = 6'(63 - int'(idiv));
        s.fbdsel    = 6'(63 - int'(fbdiv));
        s.odsel     = od;
        return s;
    endfunction

    function automatic snap_t rst_s(input logic [1:0] att, input logic [5:0] i, input logic [5:0] f, input logic [5:0] o);
        return mk(1'b1, 1'b0, 1'b0, 1'b0, att, i, f, o);
    endfunction
    function automatic snap_t wait_s(input logic [1:0] att, input logic [5:0] i, input logic [5:0] f, input logic [5:0] o);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, att, i, f, o);
    endfunction
    function automatic snap_t run_s(input logic [5:0] i, input logic [5:0] f, input logic [5:0] o);
        return mk(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, i, f, o);
    endfunction
    function automatic snap_t fault_s(input logic [1:0] att, input logic [5:0] i, input logic [5:0] f, input logic [5:0] o);
        return mk(1'b1, 1'b0, 1'b1, 1'b1, att, i, f, o);
    endfunction

    task automatic push(input int c, input string tag, input snap_t s);
        exp_t it;
        int   idx;
        it.cyc = c;
        it.tag = tag;
        it.exp = s;
        idx = q.size();
        while (idx > 0 && q[idx-1].cyc > c) idx--;
        q.insert(idx, it);
    endtask

    // Scoreboard consumer: compares every entry due at the current cycle.
    initial begin
        exp_t  it;
        snap_t obs;
        forever begin
            @(negedge clk);
            #1;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                it = q.pop_front();
                if (it.cyc < cyc) begin
                    check_val({it.tag, "_late"}, 32'(cyc), 32'(it.cyc));
                end else begin
                    obs = {pll_reset, locked, user_rst, fault, cfg_ready, attempt,
                           pll_idsel, pll_fbdsel, pll_odsel};
                    check_val(it.tag, 32'(obs), 32'(it.exp));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Expects a RESET_PLL entry at cycle e, then raises pll_lock 10 cycles into
    // WAIT_LOCK; optionally injects a 1-cycle dropout after 5 STABLE cycles.
    task automatic run_lock(input int e, input logic [5:0] i, input logic [5:0] f, input logic [5:0] o,
                            input bit glitch, output int r);
        int c;
        push(e,     "rst_enter",  rst_s(2'd0, i, f, o));
        push(e + 3, "rst_last",   rst_s(2'd0, i, f, o));
        push(e + 4, "wait_enter", wait_s(2'd0, i, f, o));
        c = e + 14;
        if (glitch) begin
            push(c + 9,  "glitch_wait", wait_s(2'd0, i, f, o));
            push(c + 17, "glitch_pre",  wait_s(2'd0, i, f, o));
            push(c + 18, "glitch_lock", run_s(i, f, o));
            wait_to(c);
            pll_lock = 1'b1;
            wait_to(c + 6);
            pll_lock = 1'b0;
            wait_to(c + 7);
            pll_lock = 1'b1;
            wait_to(c + 18);
            r = c + 18;
        end else begin
            push(c + 10, "pre_lock", wait_s(2'd0, i, f, o));
            push(c + 11, "locked",   run_s(i, f, o));
            wait_to(c);
            pll_lock = 1'b1;
            wait_to(c + 11);
            r = c + 11;
        end
    endtask

    task automatic drive_cfg(input logic [5:0] i, input logic [5:0] f, input logic [5:0] o);
        cfg_valid = 1'b1;
        cfg_idiv  = i;
        cfg_fbdiv = f;
        cfg_odsel = o;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        int r1, r2, r3, r4, r5, r6, l, e, guard;
        rst       = 1'b1;
        pll_lock  = 1'b0;
        cfg_valid = 1'b0;
        cfg_idiv  = '0;
        cfg_fbdiv = '0;
        cfg_odsel = '0;

        // Basic lock from reset
        repeat (3) @(negedge clk);
        push(cyc, "rst_hold", rst_s(2'd0, 6'd2, 6'd3, 6'd8));
        @(negedge clk);
        rst = 1'b0;
        run_lock(cyc, 6'd2, 6'd3, 6'd8, 1'b0, r1);

        // Reconfiguration in RUN
        wait_to(r1 + 2);
        drive_cfg(6'd0, 6'd9, 6'd4);
        pll_lock = 1'b0;
        run_lock(r1 + 3, 6'd0, 6'd9, 6'd4, 1'b0, r2);

        // Lock loss in RUN, then a glitch during requalification
        l = r2 + 2;
        wait_to(l);
        pll_lock = 1'b0;
        push(l + 2, "run_before_loss", run_s(6'd0, 6'd9, 6'd4));
        run_lock(l + 3, 6'd0, 6'd9, 6'd4, 1'b1, r3);

        // Lock loss and cfg hitting the same edge
        l = r3 + 2;
        wait_to(l);
        pll_lock = 1'b0;
        push(l + 2, "run_before_both", run_s(6'd0, 6'd9, 6'd4));
        wait_to(l + 2);
        drive_cfg(6'd5, 6'd17, 6'd2);
        run_lock(l + 3, 6'd5, 6'd17, 6'd2, 1'b0, r4);

        // Reconfig, then rst mid-STABLE
        wait_to(r4 + 2);
        drive_cfg(6'd1, 6'd4, 6'd16);
        pll_lock = 1'b0;
        e = r4 + 3;
        push(e,      "cfg2_rst",    rst_s(2'd0, 6'd1, 6'd4, 6'd16));
        push(e + 4,  "cfg2_wait",   wait_s(2'd0, 6'd1, 6'd4, 6'd16));
        push(e + 20, "cfg2_stable", wait_s(2'd0, 6'd1, 6'd4, 6'd16));
        wait_to(e + 14);
        pll_lock = 1'b1;
        wait_to(e + 20);
        rst      = 1'b1;
        pll_lock = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_lock(e + 21, 6'd2, 6'd3, 6'd8, 1'b0, r5);

        // Timeouts, retries, fault and recovery via cfg
        l = r5 + 2;
        wait_to(l);
        pll_lock = 1'b0;
        e = l + 3;
        push(l + 2,   "to_run",    run_s(6'd2, 6'd3, 6'd8));
        push(e,       "to_rst0",   rst_s(2'd0, 6'd2, 6'd3, 6'd8));
        push(e + 4,   "to_wait0",  wait_s(2'd0, 6'd2, 6'd3, 6'd8));
        push(e + 35,  "to_end0",   wait_s(2'd0, 6'd2, 6'd3, 6'd8));
        push(e + 36,  "to_rst1",   rst_s(2'd1, 6'd2, 6'd3, 6'd8));
        push(e + 39,  "to_rst1_l", rst_s(2'd1, 6'd2, 6'd3, 6'd8));
        push(e + 40,  "to_wait1",  wait_s(2'd1, 6'd2, 6'd3, 6'd8));
        push(e + 60,  "cfg_ignored", wait_s(2'd1, 6'd2, 6'd3, 6'd8));
        push(e + 71,  "to_end1",   wait_s(2'd1, 6'd2, 6'd3, 6'd8));
        push(e + 72,  "to_rst2",   rst_s(2'd2, 6'd2, 6'd3, 6'd8));
        push(e + 75,  "to_rst2_l", rst_s(2'd2, 6'd2, 6'd3, 6'd8));
        push(e + 76,  "to_wait2",  wait_s(2'd2, 6'd2, 6'd3, 6'd8));
        push(e + 107, "to_end2",   wait_s(2'd2, 6'd2, 6'd3, 6'd8));
        push(e + 108, "fault",     fault_s(2'd2, 6'd2, 6'd3, 6'd8));
        push(e + 120, "fault_hold", fault_s(2'd2, 6'd2, 6'd3, 6'd8));
        wait_to(e + 50);
        drive_cfg(6'd7, 6'd7, 6'd7);
        wait_to(e + 110);
        pll_lock = 1'b1;
        wait_to(e + 121);
        pll_lock = 1'b0;
        drive_cfg(6'd3, 6'd7, 6'd1);
        run_lock(e + 122, 6'd3, 6'd7, 6'd1, 1'b0, r6);

        wait_to(r6 + 3);
        guard = 0;
        while (q.size() > 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        #2;
        check_val("queue_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
